// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan code decoder: folds E0/F0/E1 prefix sequences into single key events queued in a show-ahead FIFO.
// Optional autorepeat suppression is compiled in with `define TYPEMATIC_FILTER_EN.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int PAUSE_SKIP = 7
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    input  logic                          rx_err,
    input  logic                          evt_ready,
    output logic                          evt_valid,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [7:0]                    err_cnt,
    output logic [7:0]                    leds
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(PAUSE_SKIP + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_PAUSE
    } state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } evt_t;

    state_t        state;
    logic [CW-1:0] skip_cnt;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    evt_t          mem [FIFO_DEPTH];
    evt_t          head;

    logic push_req;
    logic push_ok;
    evt_t push_evt;
    logic full;
    logic empty;
    logic pop;
    logic push_accept;
    logic push_drop;
    logic rx_byte;
    logic is_fake_shift;
    logic is_ack;

    assign rx_byte       = rx_valid && !rx_err;
    assign is_fake_shift = (rx_data == 8'h12) || (rx_data == 8'h59);
    assign is_ack        = (rx_data == 8'hAA) || (rx_data == 8'hFA) || (rx_data == 8'hFE) ||
                           (rx_data == 8'hEE) || (rx_data == 8'h00) || (rx_data == 8'hFF);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        push_req = 1'b0;
        push_evt = '{code: rx_data, ext: 1'b0, brk: 1'b0};
        if (rx_byte) begin
            case (state)
                S_IDLE: push_req = !is_ack && (rx_data != 8'hE0) && (rx_data != 8'hF0) && (rx_data != 8'hE1);
                S_EXT: begin
                    push_req     = (rx_data != 8'hF0) && !is_fake_shift;
                    push_evt.ext = 1'b1;
                end
                S_BRK: begin
                    push_req     = 1'b1;
                    push_evt.brk = 1'b1;
                end
                S_EXT_BRK: begin
                    push_req     = !is_fake_shift;
                    push_evt.ext = 1'b1;
                    push_evt.brk = 1'b1;
                end
                S_PAUSE: begin
                    push_req      = (skip_cnt == CW'(1));
                    push_evt.code = 8'hE1;
                end
                default: push_req = 1'b0;
            endcase
        end
    end

`ifdef TYPEMATIC_FILTER_EN
    logic [7:0] held_code;
    logic       held_ext;
    logic       held_valid;
    logic       held_match;

    assign held_match = held_valid && (push_evt.code == held_code) && (push_evt.ext == held_ext);
    assign push_ok    = push_req && !(held_match && !push_evt.brk);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_code  <= 8'h00;
            held_ext   <= 1'b0;
            held_valid <= 1'b0;
        end else if (push_accept && !push_evt.brk) begin
            held_code  <= push_evt.code;
            held_ext   <= push_evt.ext;
            held_valid <= 1'b1;
        end else if (push_req && push_evt.brk && held_match) begin
            held_valid <= 1'b0;
        end
    end
`else
    assign push_ok = push_req;
`endif

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop         = !empty && evt_ready;
    assign push_accept = push_ok && (!full || pop);
    assign push_drop   = push_ok && full && !pop;

    // NOTE: sequential state is assigned with non-blocking <= only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            skip_cnt <= '0;
        end else if (rx_err) begin
            state <= S_IDLE;
        end else if (rx_valid) begin
            case (state)
                S_IDLE: begin
                    if (rx_data == 8'hE0) begin
                        state <= S_EXT;
                    end else if (rx_data == 8'hF0) begin
                        state <= S_BRK;
                    end else if (rx_data == 8'hE1) begin
                        state    <= S_PAUSE;
                        skip_cnt <= CW'(PAUSE_SKIP);
                    end
                end
                S_EXT:     state <= (rx_data == 8'hF0) ? S_EXT_BRK : S_IDLE;
                S_BRK:     state <= S_IDLE;
                S_EXT_BRK: state <= S_IDLE;
                S_PAUSE: begin
                    skip_cnt <= skip_cnt - CW'(1);
                    if (skip_cnt == CW'(1)) state <= S_IDLE;
                end
                default:   state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            leds     <= 8'h00;
        end else begin
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (!push_evt.brk) leds <= push_evt.code;
            end
            if (push_drop) overflow <= 1'b1;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (push_accept) mem[wr_ptr[AW-1:0]] <= push_evt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'h00;
        end else if (rx_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end

    assign head       = mem[rd_ptr[AW-1:0]];
    assign evt_valid  = !empty;
    assign evt_code   = head.code;
    assign evt_ext    = head.ext;
    assign evt_break  = head.brk;
    assign fifo_level = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: directed scenarios plus random byte streams against a sequence-level model.
// Build with +define+TYPEMATIC_FILTER_EN to exercise the autorepeat filter variant.
module tb_ps2_scancode_decoder;

    localparam int FIFO_DEPTH = 4;
    localparam int PAUSE_SKIP = 7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       evt_ready;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic       overflow;
    logic [7:0] err_cnt;
    logic [7:0] leds;

    ps2_scancode_decoder #(.FIFO_DEPTH(FIFO_DEPTH), .PAUSE_SKIP(PAUSE_SKIP)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_code(evt_code), .evt_ext(evt_ext),
        .evt_break(evt_break), .fifo_level(fifo_level), .overflow(overflow), .err_cnt(err_cnt),
        .leds(leds)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: raw bytes of the sequence in progress plus a queue of {code,ext,brk} events.
    logic [7:0] seq [$];
    logic [9:0] mq [$];
    logic [7:0] m_leds;
    bit         m_ovf;
    int         m_err;
`ifdef TYPEMATIC_FILTER_EN
    logic [8:0] held;
    bit         held_valid;
`endif

    function automatic bit is_fake(input logic [7:0] b);
        return (b == 8'h12) || (b == 8'h59);
    endfunction

    function automatic bit is_ack(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) || (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    task automatic model_reset();
        seq.delete();
        mq.delete();
        m_leds = 8'h00;
        m_ovf  = 1'b0;
        m_err  = 0;
`ifdef TYPEMATIC_FILTER_EN
        held       = '0;
        held_valid = 1'b0;
`endif
    endtask

    task automatic model_update(input bit v, input logic [7:0] d, input bit e, input bit r);
        bit         has = 1'b0;
        logic [9:0] ev  = '0;
        bit         full_pre = (mq.size() == FIFO_DEPTH);
        bit         pop = r && (mq.size() > 0);
        if (e) begin
            seq.delete();
            if (m_err != 255) m_err++;
        end else if (v) begin
            seq.push_back(d);
            if (seq[0] == 8'hE1) begin
                if (seq.size() == PAUSE_SKIP + 1) begin
                    has = 1'b1; ev = {8'hE1, 2'b00}; seq.delete();
                end
            end else if (seq[0] == 8'hF0) begin
                if (seq.size() == 2) begin
                    has = 1'b1; ev = {seq[1], 2'b01}; seq.delete();
                end
            end else if (seq[0] == 8'hE0) begin
                if (seq.size() == 2 && seq[1] != 8'hF0) begin
                    has = !is_fake(seq[1]); ev = {seq[1], 2'b10}; seq.delete();
                end else if (seq.size() == 3) begin
                    has = !is_fake(seq[2]); ev = {seq[2], 2'b11}; seq.delete();
                end
            end else begin
                has = !is_ack(seq[0]); ev = {seq[0], 2'b00}; seq.delete();
            end
        end
`ifdef TYPEMATIC_FILTER_EN
        if (has && held_valid && held == ev[9:1]) begin
            if (!ev[0]) has = 1'b0;
            else        held_valid = 1'b0;
        end
`endif
        if (pop) void'(mq.pop_front());
        if (has) begin
            if (!full_pre || pop) begin
                mq.push_back(ev);
                if (!ev[0]) begin
                    m_leds = ev[9:2];
`ifdef TYPEMATIC_FILTER_EN
                    held       = ev[9:1];
                    held_valid = 1'b1;
`endif
                end
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    // Drive one cycle from a falling edge, advance the model, return at the next falling edge.
    task automatic step(input bit v, input logic [7:0] d, input bit e, input bit r);
        rx_valid = v; rx_data = d; rx_err = e; evt_ready = r;
        model_update(v, d, e, r);
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0; rx_err = 1'b0; evt_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_valid = 1'b0; rx_err = 1'b0; evt_ready = 1'b0; rx_data = 8'h00;
        model_reset();
        #12;
        n_vec++;
        if (evt_valid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b0 || err_cnt !== 8'h00 || leds !== 8'h00) begin
            n_bad++;
            $display("FAIL reset: valid=%b level=%0d ovf=%b err=%h leds=%h, want 0 0 0 00 00",
                     evt_valid, fifo_level, overflow, err_cnt, leds);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_make();
        step(1, 8'h1C, 0, 0);
        n_vec++;
        if (evt_valid !== 1'b1 || {evt_code, evt_ext, evt_break} !== {8'h1C, 2'b00} || leds !== 8'h1C || fifo_level !== 3'd1) begin
            n_bad++;
            $display("FAIL make: v=%b evt=%h/%b/%b leds=%h lvl=%0d, want 1 1C/0/0 1C 1",
                     evt_valid, evt_code, evt_ext, evt_break, leds, fifo_level);
        end
        step(0, 8'h00, 0, 1);
        n_vec++;
        if (evt_valid !== 1'b0 || fifo_level !== 3'd0) begin
            n_bad++;
            $display("FAIL make_pop: v=%b lvl=%0d, want 0 0", evt_valid, fifo_level);
        end
    endtask

    task automatic test_ext_break();
        step(1, 8'hE0, 0, 0);
        step(1, 8'hF0, 0, 0);
        n_vec++;
        if (fifo_level !== 3'd0) begin
            n_bad++;
            $display("FAIL ext_break_prefix: lvl=%0d, want 0", fifo_level);
        end
        step(1, 8'h75, 0, 0);
        n_vec++;
        if (fifo_level !== 3'd1 || {evt_code, evt_ext, evt_break} !== {8'h75, 2'b11} || leds !== 8'h1C) begin
            n_bad++;
            $display("FAIL ext_break: lvl=%0d evt=%h/%b/%b leds=%h, want 1 75/1/1 1C",
                     fifo_level, evt_code, evt_ext, evt_break, leds);
        end
        step(0, 8'h00, 0, 1);
    endtask

    task automatic test_pause();
        logic [7:0] pbytes [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 7; i++) step(1, pbytes[i], 0, 0);
        n_vec++;
        if (fifo_level !== 3'd0) begin
            n_bad++;
            $display("FAIL pause_partial: lvl=%0d, want 0", fifo_level);
        end
        step(1, pbytes[7], 0, 0);
        n_vec++;
        if (fifo_level !== 3'd1 || {evt_code, evt_ext, evt_break} !== {8'hE1, 2'b00} || leds !== 8'hE1) begin
            n_bad++;
            $display("FAIL pause: lvl=%0d evt=%h/%b/%b leds=%h, want 1 E1/0/0 E1",
                     fifo_level, evt_code, evt_ext, evt_break, leds);
        end
        step(0, 8'h00, 0, 1);
        step(1, 8'h2C, 0, 0);
        n_vec++;
        if (fifo_level !== 3'd1 || {evt_code, evt_ext, evt_break} !== {8'h2C, 2'b00}) begin
            n_bad++;
            $display("FAIL pause_idle: lvl=%0d evt=%h/%b/%b, want 1 2C/0/0", fifo_level, evt_code, evt_ext, evt_break);
        end
        step(0, 8'h00, 0, 1);
    endtask

    task automatic test_err();
        step(1, 8'hE0, 0, 0);
        step(1, 8'h5A, 1, 0);
        step(1, 8'h1C, 0, 0);
        n_vec++;
        if (fifo_level !== 3'd1 || {evt_code, evt_ext, evt_break} !== {8'h1C, 2'b00} || err_cnt !== 8'h01) begin
            n_bad++;
            $display("FAIL err_abort: lvl=%0d evt=%h/%b/%b err=%h, want 1 1C/0/0 01",
                     fifo_level, evt_code, evt_ext, evt_break, err_cnt);
        end
        step(0, 8'h00, 0, 1);
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5] = '{8'h15, 8'h16, 8'h1D, 8'h24, 8'h2D};
        logic [7:0] want  [4] = '{8'h16, 8'h1D, 8'h24, 8'h35};
        for (int i = 0; i < 5; i++) step(1, codes[i], 0, 0);
        n_vec++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1 || leds !== 8'h24) begin
            n_bad++;
            $display("FAIL overflow: lvl=%0d ovf=%b leds=%h, want 4 1 24", fifo_level, overflow, leds);
        end
        step(1, 8'h35, 0, 1);
        n_vec++;
        if (fifo_level !== 3'd4 || leds !== 8'h35) begin
            n_bad++;
            $display("FAIL full_push_pop: lvl=%0d leds=%h, want 4 35", fifo_level, leds);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (evt_valid !== 1'b1 || evt_code !== want[i]) begin
                n_bad++;
                $display("FAIL drain_order[%0d]: v=%b code=%h, want 1 %h", i, evt_valid, evt_code, want[i]);
            end
            step(0, 8'h00, 0, 1);
        end
        n_vec++;
        if (fifo_level !== 3'd0 || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL drained: lvl=%0d ovf=%b, want 0 1", fifo_level, overflow);
        end
    endtask

    task automatic test_typematic();
        logic [7:0] bytes [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
        logic [9:0] got [$];
`ifdef TYPEMATIC_FILTER_EN
        logic [9:0] exp [$] = '{{8'h1C, 2'b00}, {8'h1C, 2'b01}, {8'h1C, 2'b00}};
`else
        logic [9:0] exp [$] = '{{8'h1C, 2'b00}, {8'h1C, 2'b00}, {8'h1C, 2'b00}, {8'h1C, 2'b01}, {8'h1C, 2'b00}};
`endif
        for (int i = 0; i < 9; i++) begin
            if (evt_valid) got.push_back({evt_code, evt_ext, evt_break});
            if (i < 6) step(1, bytes[i], 0, 1);
            else       step(0, 8'h00, 0, 1);
        end
        n_vec++;
        if (got.size() != exp.size()) begin
            n_bad++;
            $display("FAIL typematic_count: got %0d events, want %0d", got.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                n_vec++;
                if (got[i] !== exp[i]) begin
                    n_bad++;
                    $display("FAIL typematic[%0d]: got %h, want %h", i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] b;
            int sel = $urandom_range(0, 19);
            case (sel)
                0, 1, 2: b = 8'hE0;
                3, 4, 5: b = 8'hF0;
                6:       b = 8'hE1;
                7:       b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
                8:       b = 8'hAA;
                9, 10:   b = 8'h1C;
                default: b = 8'($urandom_range(0, 255));
            endcase
            step($urandom_range(0, 9) < 6, b, $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 4);
            n_vec++;
            if (evt_valid !== (mq.size() > 0) || int'(fifo_level) != mq.size() || overflow !== m_ovf ||
                int'(err_cnt) != m_err || leds !== m_leds ||
                (mq.size() > 0 && {evt_code, evt_ext, evt_break} !== mq[0])) begin
                n_bad++;
                $display("FAIL random[%0d]: v=%b lvl=%0d evt=%h/%b/%b ovf=%b err=%0d leds=%h, want lvl=%0d head=%h ovf=%b err=%0d leds=%h",
                         i, evt_valid, fifo_level, evt_code, evt_ext, evt_break, overflow, err_cnt, leds,
                         mq.size(), (mq.size() > 0) ? mq[0] : 10'h0, m_ovf, m_err, m_leds);
            end
        end
    endtask

    initial begin
        test_reset();
        test_make();
        test_ext_break();
        test_pause();
        test_err();
        test_overflow();
        test_typematic();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
